// File: rtl/dt_skel.sv
// Skeleton scan over the 128x128 distance-transform result: an interior pixel is kept when it
// is non-zero and not smaller than any of its N/W/E/S neighbours; bits are packed 16 per word.
module dt_skel (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        sk_wr,
    output logic [9:0]  sk_addr,
    output logic [15:0] sk_do,
    output logic [7:0]  max_dist,
    output logic [13:0] sk_cnt
);

    typedef enum logic [2:0] {IDLE, RD_C, RD_NB, EVAL, WRITE, FIN} state_t;

    state_t      state, state_nx;
    logic [13:0] pos;
    logic [6:0]  row, col;
    logic [1:0]  nb_idx;
    logic [7:0]  centre;
    logic        ge_all;
    logic [15:0] word_sr;
    logic        border;
    logic        rd_nx;
    logic [13:0] addr_nx;
    logic        pix_done;
    logic        pix_bit;

    assign row    = pos[13:7];
    assign col    = pos[6:0];
    assign border = (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
    assign busy   = (state != IDLE) && (state != FIN);
    assign done   = (state == FIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Read data for the address shown in a cycle is consumed at the end of that same cycle.
    always_comb begin
        state_nx = state;
        rd_nx    = 1'b0;
        addr_nx  = res_addr;
        pix_done = 1'b0;
        pix_bit  = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RD_C;
            RD_C: begin
                if (border) begin
                    pix_done = 1'b1;
                end else begin
                    rd_nx    = 1'b1;
                    addr_nx  = pos;
                    state_nx = RD_NB;
                end
            end
            RD_NB: begin
                case (nb_idx)
                    2'd0: begin
                        if (res_di == 8'd0) begin
                            pix_done = 1'b1;
                        end else begin
                            rd_nx   = 1'b1;
                            addr_nx = pos - 14'd128;
                        end
                    end
                    2'd1: begin
                        rd_nx   = 1'b1;
                        addr_nx = pos - 14'd1;
                    end
                    2'd2: begin
                        rd_nx   = 1'b1;
                        addr_nx = pos + 14'd1;
                    end
                    default: begin
                        rd_nx    = 1'b1;
                        addr_nx  = pos + 14'd128;
                        state_nx = EVAL;
                    end
                endcase
            end
            EVAL: begin
                pix_done = 1'b1;
                pix_bit  = ge_all && (centre >= res_di);
            end
            WRITE:   state_nx = (pos == 14'h3FFF) ? FIN : RD_C;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (pix_done) state_nx = (col[3:0] == 4'hF) ? WRITE : RD_C;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_rd   <= 1'b0;
            res_addr <= 14'd0;
            sk_wr    <= 1'b0;
            sk_addr  <= 10'd0;
            sk_do    <= 16'd0;
            max_dist <= 8'd0;
            sk_cnt   <= 14'd0;
            pos      <= 14'd0;
            nb_idx   <= 2'd0;
            centre   <= 8'd0;
            ge_all   <= 1'b0;
            word_sr  <= 16'd0;
        end else begin
            res_rd   <= rd_nx;
            res_addr <= addr_nx;
            sk_wr    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        max_dist <= 8'd0;
                        sk_cnt   <= 14'd0;
                        pos      <= 14'd0;
                        word_sr  <= 16'd0;
                    end
                end
                RD_C: nb_idx <= 2'd0;
                RD_NB: begin
                    nb_idx <= nb_idx + 2'd1;
                    if (nb_idx == 2'd0) begin
                        centre <= res_di;
                        ge_all <= 1'b1;
                        if (res_di > max_dist) max_dist <= res_di;
                    end else begin
                        ge_all <= ge_all && (centre >= res_di);
                    end
                end
                WRITE: pos <= pos + 14'd1;
                default: ;
            endcase
            // The word is flushed from the WRITE state, which also advances the position.
            if (pix_done) begin
                word_sr <= {word_sr[14:0], pix_bit};
                if (pix_bit) sk_cnt <= sk_cnt + 14'd1;
                if (col[3:0] == 4'hF) begin
                    sk_wr   <= 1'b1;
                    sk_addr <= {row, col[6:4]};
                    sk_do   <= {word_sr[14:0], pix_bit};
                end else begin
                    pos <= pos + 14'd1;
                end
            end
        end
    end

endmodule
